speck_key_schedule: RTL and testbench



---
 rtl/speck_key_schedule.sv | 161 ++++++++++++++++
 tb/tb_speck_key_schedule.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/speck_key_schedule.sv
// -----------------------------------------------------------------------------
// speck_key_schedule
//
// Round-key generator for SPECK64/128. A 128-bit master key is captured on a
// start pulse and expanded with the SPECK key-schedule recurrence. One 32-bit
// round key is presented per round on a valid/ready stream. Every accepted key
// is also written into a local register file for later random-access reads.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears state and register file)
//   start     single-cycle request, honoured only while idle
//   key       master key {l2, l1, l0, k0}, k0 = key[31:0]
//   busy      high while the schedule is being expanded
//   rk_valid  round key available on rk_data
//   rk_ready  downstream accepts the key when rk_valid & rk_ready
//   rk_data   current round key k_i
//   rk_idx    round index i of rk_data
//   done      one-cycle pulse after the final key is accepted
//   rd_addr   register-file read address
//   rd_data   combinational read of round key rd_addr (0 when out of range)
// -----------------------------------------------------------------------------
module speck_key_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 27,
  parameter int ALPHA  = 8,
  parameter int BETA   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*WORD_W-1:0] key,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [WORD_W-1:0]   rk_data,
  output logic [4:0]          rk_idx,
  output logic                done,
  input  logic [4:0]          rd_addr,
  output logic [WORD_W-1:0]   rd_data
);

  localparam logic [WORD_W-1:0] ZERO_W   = {WORD_W{1'b0}};
  localparam logic [4:0]        LAST_IDX = 5'(ROUNDS - 1);
  localparam logic [4:0]        NUM_RK   = 5'(ROUNDS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Constant-amount rotations; the amounts are parameters, so these reduce to wiring.
  function automatic logic [WORD_W-1:0] ror_w(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rol_w(input logic [WORD_W-1:0] x, input int n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  state_t              state_r;
  logic [WORD_W-1:0]   k_r;
  logic [WORD_W-1:0]   l0_r;
  logic [WORD_W-1:0]   l1_r;
  logic [WORD_W-1:0]   l2_r;
  logic [4:0]          i_r;
  logic                busy_r;
  logic                valid_r;
  logic                done_r;
  logic [WORD_W-1:0]   rf_r [ROUNDS];

  logic [WORD_W-1:0]   l_new_s;
  logic [WORD_W-1:0]   k_next_s;
  logic [WORD_W-1:0]   rd_data_s;

  // One step of the key-schedule recurrence; the round index is folded into l.
  always_comb begin
    l_new_s  = (k_r + ror_w(l0_r, ALPHA)) ^ WORD_W'(i_r);
    k_next_s = rol_w(k_r, BETA) ^ l_new_s;
  end

  // Control FSM, key-schedule state and register-file writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      k_r     <= ZERO_W;
      l0_r    <= ZERO_W;
      l1_r    <= ZERO_W;
      l2_r    <= ZERO_W;
      i_r     <= 5'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      for (int j = 0; j < ROUNDS; j++) begin
        rf_r[j] <= ZERO_W;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            k_r     <= key[WORD_W-1:0];
            l0_r    <= key[2*WORD_W-1:WORD_W];
            l1_r    <= key[3*WORD_W-1:2*WORD_W];
            l2_r    <= key[4*WORD_W-1:3*WORD_W];
            i_r     <= 5'd0;
            busy_r  <= 1'b1;
            valid_r <= 1'b1;
            state_r <= ST_EXPAND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXPAND: begin
          // Without a handshake everything holds, so rk_data/rk_idx stay stable.
          if (rk_ready) begin
            rf_r[i_r] <= k_r;
            k_r       <= k_next_s;
            l0_r      <= l1_r;
            l1_r      <= l2_r;
            l2_r      <= l_new_s;
            i_r       <= i_r + 5'd1;
            if (i_r == LAST_IDX) begin
              busy_r  <= 1'b0;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_EXPAND;
            end
          end else begin
            state_r <= ST_EXPAND;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Random-access read port; addresses past the last round read as zero.
  always_comb begin
    rd_data_s = ZERO_W;
    if (rd_addr < NUM_RK) begin
      rd_data_s = rf_r[rd_addr];
    end else begin
      rd_data_s = ZERO_W;
    end
  end

  assign busy     = busy_r;
  assign rk_valid = valid_r;
  assign done     = done_r;
  assign rk_data  = k_r;
  assign rk_idx   = i_r;
  assign rd_data  = rd_data_s;

endmodule

// File: tb/tb_speck_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_speck_key_schedule
//
// Self-checking bench for speck_key_schedule. Expected keys come from a
// reference expansion written in the textbook array form of the SPECK key
// schedule (l[i+3], k[i+1]); the known-answer vector is also validated by
// encrypting the standard plaintext with the streamed keys.
// -----------------------------------------------------------------------------
module tb_speck_key_schedule;

  localparam logic [127:0] KAT_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_data;
  logic [4:0]   rk_idx;
  logic         done;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mk     [27];  // reference keys for the current run
  logic [31:0] cap    [27];  // keys captured at each handshake
  logic [31:0] rf_exp [27];  // expected register-file contents

  typedef struct {
    logic [127:0] key;
    logic [31:0]  k1;
    logic [31:0]  k2;
    bit           bp;
    bit           kat;
  } vec_t;

  vec_t tbl [3];

  always #5 clk = ~clk;

  speck_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror8(input logic [31:0] x);
    return {x[7:0], x[31:8]};
  endfunction

  function automatic logic [31:0] rol3(input logic [31:0] x);
    return {x[28:0], x[31:29]};
  endfunction

  // Reference key expansion in array form.
  task automatic model_keys(input logic [127:0] kin);
    logic [31:0] l  [30];
    logic [31:0] kk [27];
    kk[0] = kin[31:0];
    l[0]  = kin[63:32];
    l[1]  = kin[95:64];
    l[2]  = kin[127:96];
    for (int r = 0; r < 26; r++) begin
      l[r+3]  = (kk[r] + ror8(l[r])) ^ 32'(r);
      kk[r+1] = rol3(kk[r]) ^ l[r+3];
    end
    for (int r = 0; r < 27; r++) mk[r] = kk[r];
  endtask

  // SPECK64 encryption using the captured round keys.
  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [31:0] x;
    logic [31:0] y;
    x = pt[63:32];
    y = pt[31:0];
    for (int r = 0; r < 27; r++) begin
      x = (ror8(x) + y) ^ cap[r];
      y = rol3(y) ^ x;
    end
    return {x, y};
  endfunction

  // Start an expansion from the current cycle and follow it to the done cycle.
  // Returns at #1 after the edge that raises done, so a caller may restart at once.
  task automatic run(input logic [127:0] kin, input bit bp, input int glitch_at);
    int          cnt;
    int          cyc;
    bit          rdy;
    bit          stall;
    bit          gl;
    logic [31:0] pd;
    logic [4:0]  pi;
    model_keys(kin);
    key   = kin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key   = ~kin;  // must not be re-sampled
    cnt = 0; cyc = 0; stall = 0; gl = 0;
    pd = 32'd0; pi = 5'd0;
    while (cnt < 27 && cyc < 2000) begin
      chk("busy_high", 32'(busy), 32'd1);
      chk("rk_valid_high", 32'(rk_valid), 32'd1);
      chk("done_low_stream", 32'(done), 32'd0);
      chk("rk_idx", 32'(rk_idx), 32'(cnt));
      chk("rk_data", rk_data, mk[cnt]);
      if (stall) begin
        chk("stall_data", rk_data, pd);
        chk("stall_idx", 32'(rk_idx), 32'(pi));
      end
      start = 1'b0;
      if (glitch_at == cnt && !gl) begin
        start = 1'b1;
        key   = kin ^ 128'h5a5a5a5a_a5a5a5a5_12345678_87654321;
        gl    = 1'b1;
      end
      rdy      = bp ? ($urandom_range(0, 99) >= 40) : 1'b1;
      rk_ready = rdy;
      rd_addr  = 5'(cnt);
      #1;
      chk("rf_before_hs", rd_data, rf_exp[cnt]);
      pd = rk_data;
      pi = rk_idx;
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        cap[cnt] = pd;
        chk("rf_after_hs", rd_data, mk[cnt]);
        rf_exp[cnt] = mk[cnt];
        cnt++;
        stall = 1'b0;
      end else begin
        stall = 1'b1;
      end
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    if (cnt < 27) chk("stream_timeout", 32'(cnt), 32'd27);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_low_done", 32'(busy), 32'd0);
    chk("rk_valid_low_done", 32'(rk_valid), 32'd0);
    if (!bp) chk("done_latency", 32'(cyc + 1), 32'd28);
  endtask

  task automatic sweep_rf(input string name);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1;
      chk(name, rd_data, (a < 27) ? rf_exp[a] : 32'd0);
    end
  endtask

  initial begin
    logic [63:0]  ct;
    logic [127:0] rk;

    tbl[0] = '{key: KAT_KEY,  k1: 32'h131d0309, k2: 32'hbbd80d53, bp: 1'b0, kat: 1'b1};
    tbl[1] = '{key: 128'd0,   k1: 32'h00000000, k2: 32'h00000001, bp: 1'b0, kat: 1'b0};
    tbl[2] = '{key: KAT_KEY,  k1: 32'h131d0309, k2: 32'hbbd80d53, bp: 1'b1, kat: 1'b1};

    rst_n = 1'b0; start = 1'b0; key = 128'd0; rk_ready = 1'b0; rd_addr = 5'd0;
    for (int r = 0; r < 27; r++) rf_exp[r] = 32'd0;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rk_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", rk_data, 32'd0);
    chk("rst_idx", 32'(rk_idx), 32'd0);
    sweep_rf("rst_rf");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table runs, each after the first starting in the previous done cycle
    for (int t = 0; t < 3; t++) begin
      run(tbl[t].key, tbl[t].bp, -1);
      chk("tbl_k0", cap[0], tbl[t].key[31:0]);
      chk("tbl_k1", cap[1], tbl[t].k1);
      chk("tbl_k2", cap[2], tbl[t].k2);
      if (tbl[t].kat) begin
        ct = encrypt(64'h3b726574_7475432d);
        chk("kat_ct_hi", ct[63:32], 32'h8c6fa548);
        chk("kat_ct_lo", ct[31:0], 32'h454e028b);
      end
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    sweep_rf("readback");

    // start while busy is ignored
    run(KAT_KEY, 1'b1, 5);
    chk("glitch_k26", cap[26], mk[26]);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an expansion
    key = KAT_KEY; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_idx", 32'(rk_idx), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(rk_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", rk_data, 32'd0);
    chk("arst_idx", 32'(rk_idx), 32'd0);
    for (int r = 0; r < 27; r++) rf_exp[r] = 32'd0;
    sweep_rf("arst_rf");
    rk_ready = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run(KAT_KEY, 1'b0, -1);
    ct = encrypt(64'h3b726574_7475432d);
    chk("post_rst_ct_hi", ct[63:32], 32'h8c6fa548);
    chk("post_rst_ct_lo", ct[31:0], 32'h454e028b);

    // Random keys with backpressure against the reference expansion
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run(rk, 1'b1, -1);
    end
    sweep_rf("rand_readback");
    @(posedge clk); #1;
    chk("final_done_low", 32'(done), 32'd0);
    chk("final_busy_low", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
